// File: rtl/mem_copy_engine.sv
// mem_copy_engine: memmove-style block copy engine driving an 8-bit data memory.
// One byte per READ/WRITE cycle pair; direction chosen at start so overlaps copy correctly.
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] memDataIn,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataOut,
    output logic              memWriteEnable,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              back_q, back_d;
    logic [ADDR_W-1:0] diff;
    logic              go_back;

    // Backward copy only when the destination starts inside the source run.
    assign diff    = dstAddr - srcAddr;
    assign go_back = (diff != '0) && (diff < len);

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            back_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            back_q  <= back_d;
        end
    end

    // Next-state and pointer/counter updates.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        back_d  = back_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    back_d = go_back;
                    cnt_d  = len;
                    if (go_back) begin
                        src_d = srcAddr + len - ADDR_W'(1);
                        dst_d = dstAddr + len - ADDR_W'(1);
                    end else begin
                        src_d = srcAddr;
                        dst_d = dstAddr;
                    end
                    state_d = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                hold_d  = memDataIn;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                src_d   = back_q ? src_q - ADDR_W'(1) : src_q + ADDR_W'(1);
                dst_d   = back_q ? dst_q - ADDR_W'(1) : dst_q + ADDR_W'(1);
                cnt_d   = cnt_q - ADDR_W'(1);
                state_d = (cnt_q == ADDR_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory-side and status outputs decoded from registered state only.
    always_comb begin
        memAddr        = '0;
        memDataOut     = hold_q;
        memWriteEnable = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (state_q)
            S_READ: begin
                memAddr = src_q;
                busy    = 1'b1;
            end
            S_WRITE: begin
                memAddr        = dst_q;
                memWriteEnable = 1'b1;
                busy           = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                memAddr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: drives copies into a behavioural 256-byte memory and
// checks results against a memmove reference computed with a temp buffer.
module tb_mem_copy_engine;

    logic       clk;
    logic       resetN;
    logic       start;
    logic [7:0] srcAddr;
    logic [7:0] dstAddr;
    logic [7:0] len;
    logic [7:0] memDataIn;
    logic [7:0] memAddr;
    logic [7:0] memDataOut;
    logic       memWriteEnable;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    logic [7:0] mem [256];
    logic [7:0] expm [256];
    logic [7:0] addr_q [$];
    logic [7:0] wr_q [$];

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk),
        .resetN(resetN),
        .start(start),
        .srcAddr(srcAddr),
        .dstAddr(dstAddr),
        .len(len),
        .memDataIn(memDataIn),
        .memAddr(memAddr),
        .memDataOut(memDataOut),
        .memWriteEnable(memWriteEnable),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memDataIn = mem[memAddr];

    always @(posedge clk) begin
        if (memWriteEnable) mem[memAddr] = memDataOut;
    end

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // Reference: memmove through a temporary buffer.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] l);
        logic [7:0] tmp [256];
        for (int i = 0; i < 256; i++) expm[i] = mem[i];
        for (int i = 0; i < int'(l); i++) tmp[i] = mem[8'(s + 8'(i))];
        for (int i = 0; i < int'(l); i++) expm[8'(d + 8'(i))] = tmp[i];
    endtask

    function automatic int mem_diff(output int first);
        int n;
        n = 0;
        first = -1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== expm[i]) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    // Starts a copy and observes a fixed window of cycles after the accepting edge.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input int inj,
                            output int done_cyc, output int ndone,
                            output int nbusy, output int both);
        @(negedge clk);
        start = 1'b1;
        srcAddr = s;
        dstAddr = d;
        len = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        srcAddr = 8'($urandom);
        dstAddr = 8'($urandom);
        len = 8'($urandom);
        addr_q.delete();
        wr_q.delete();
        done_cyc = -1;
        ndone = 0;
        nbusy = 0;
        both = 0;
        for (int k = 1; k <= 2 * int'(l) + 4; k++) begin
            @(negedge clk);
            if (busy) begin
                addr_q.push_back(memAddr);
                nbusy++;
            end
            if (memWriteEnable) wr_q.push_back(memAddr);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (busy && done) both++;
            if (k == inj) begin
                start = 1'b1;
                srcAddr = 8'h00;
                dstAddr = 8'h00;
                len = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        start = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        len = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        checks++;
        if (memWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: got %b want 0", memWriteEnable);
        end
        checks++;
        if (memAddr !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h want 00", memAddr);
        end
        checks++;
        if (memDataOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_wdata: got %h want 00", memDataOut);
        end
        resetN = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_forward();
        int dc, nd, nb, bo, fi, nbad;
        fill_random();
        mem[8'h10] = 8'hA1;
        mem[8'h11] = 8'hB2;
        mem[8'h12] = 8'hC3;
        mem[8'h13] = 8'hD4;
        model_copy(8'h10, 8'h40, 8'd4);
        run_copy(8'h10, 8'h40, 8'd4, 0, dc, nd, nb, bo);
        nbad = mem_diff(fi);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL fwd_data: %0d bad bytes, first at %0d", nbad, fi);
        end
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("FAIL fwd_done_cycle: got %0d want 9", dc);
        end
        checks++;
        if (wr_q.size() !== 4) begin
            errors++;
            $display("FAIL fwd_writes: got %0d want 4", wr_q.size());
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL fwd_done_pulses: got %0d want 1", nd);
        end
        checks++;
        if (nb !== 8) begin
            errors++;
            $display("FAIL fwd_busy_cycles: got %0d want 8", nb);
        end
        checks++;
        if (bo !== 0) begin
            errors++;
            $display("FAIL fwd_busy_and_done: got %0d want 0", bo);
        end
    endtask

    task automatic test_overlap_back();
        int dc, nd, nb, bo, fi, nbad;
        fill_random();
        mem[8'h10] = 8'h01;
        mem[8'h11] = 8'h02;
        mem[8'h12] = 8'h03;
        mem[8'h13] = 8'h04;
        model_copy(8'h10, 8'h12, 8'd4);
        run_copy(8'h10, 8'h12, 8'd4, 0, dc, nd, nb, bo);
        nbad = mem_diff(fi);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL back_data: %0d bad bytes, first at %0d", nbad, fi);
        end
        checks++;
        if (wr_q.size() < 1 || wr_q[0] !== 8'h15) begin
            errors++;
            $display("FAIL back_first_write: got %h want 15",
                     wr_q.size() > 0 ? wr_q[0] : 8'hxx);
        end
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("FAIL back_done_cycle: got %0d want 9", dc);
        end
    endtask

    task automatic test_wrap();
        int dc, nd, nb, bo, fi, nbad;
        logic [7:0] seq [8];
        seq = '{8'hFE, 8'h80, 8'hFF, 8'h81, 8'h00, 8'h82, 8'h01, 8'h83};
        fill_random();
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        mem[8'h00] = 8'h33;
        mem[8'h01] = 8'h44;
        model_copy(8'hFE, 8'h80, 8'd4);
        run_copy(8'hFE, 8'h80, 8'd4, 0, dc, nd, nb, bo);
        nbad = mem_diff(fi);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL wrap_data: %0d bad bytes, first at %0d", nbad, fi);
        end
        checks++;
        if (addr_q.size() !== 8) begin
            errors++;
            $display("FAIL wrap_addr_count: got %0d want 8", addr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (addr_q[i] !== seq[i]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d]: got %h want %h",
                             i, addr_q[i], seq[i]);
                end
            end
        end
    endtask

    task automatic test_len0();
        int dc, nd, nb, bo, fi, nbad;
        fill_random();
        model_copy(8'h05, 8'h06, 8'd0);
        run_copy(8'h05, 8'h06, 8'd0, 0, dc, nd, nb, bo);
        nbad = mem_diff(fi);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL len0_data: %0d bad bytes, first at %0d", nbad, fi);
        end
        checks++;
        if (wr_q.size() !== 0) begin
            errors++;
            $display("FAIL len0_writes: got %0d want 0", wr_q.size());
        end
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL len0_done_cycle: got %0d want 1", dc);
        end
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL len0_busy_cycles: got %0d want 0", nb);
        end
    endtask

    task automatic test_start_busy();
        int dc, nd, nb, bo, fi, nbad;
        fill_random();
        model_copy(8'h20, 8'h60, 8'd4);
        run_copy(8'h20, 8'h60, 8'd4, 3, dc, nd, nb, bo);
        nbad = mem_diff(fi);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL busy_start_data: %0d bad bytes, first at %0d",
                     nbad, fi);
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL busy_start_done_pulses: got %0d want 1", nd);
        end
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("FAIL busy_start_done_cycle: got %0d want 9", dc);
        end
        checks++;
        if (wr_q.size() !== 4) begin
            errors++;
            $display("FAIL busy_start_writes: got %0d want 4", wr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        mem[8'h10] = 8'hA1;
        mem[8'h11] = 8'hB2;
        mem[8'h12] = 8'hC3;
        mem[8'h13] = 8'hD4;
        mem[8'h40] = 8'h00;
        mem[8'h41] = 8'h00;
        mem[8'h42] = 8'h00;
        mem[8'h43] = 8'h00;
        @(negedge clk);
        start = 1'b1;
        srcAddr = 8'h10;
        dstAddr = 8'h40;
        len = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (memAddr !== 8'h12 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: addr %h busy %b want 12 1",
                     memAddr, busy);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if (memWriteEnable !== 1'b0 || busy !== 1'b0 || memAddr !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async: we %b busy %b addr %h want 0 0 00",
                     memWriteEnable, busy, memAddr);
        end
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: busy %b done %b want 0 0", busy, done);
        end
        checks++;
        if (mem[8'h40] !== 8'hA1 || mem[8'h41] !== 8'hB2) begin
            errors++;
            $display("FAIL rst_mid_written: got %h %h want A1 B2",
                     mem[8'h40], mem[8'h41]);
        end
        checks++;
        if (mem[8'h42] !== 8'h00 || mem[8'h43] !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_untouched: got %h %h want 00 00",
                     mem[8'h42], mem[8'h43]);
        end
    endtask

    task automatic test_random();
        int dc, nd, nb, bo, fi, nbad, want;
        logic [7:0] s, d, l;
        for (int it = 0; it < 24; it++) begin
            fill_random();
            s = 8'($urandom);
            l = 8'($urandom_range(0, 60));
            if ($urandom_range(0, 1) == 1) d = s + 8'($urandom_range(0, 8));
            else if ($urandom_range(0, 1) == 1) d = s - 8'($urandom_range(0, 8));
            else d = 8'($urandom);
            model_copy(s, d, l);
            run_copy(s, d, l, 0, dc, nd, nb, bo);
            want = (l == 8'd0) ? 1 : 2 * int'(l) + 1;
            nbad = mem_diff(fi);
            checks++;
            if (nbad !== 0) begin
                errors++;
                $display("FAIL rand_data[%0d]: src %h dst %h len %0d, %0d bad, first %0d",
                         it, s, d, l, nbad, fi);
            end
            checks++;
            if (dc !== want || nd !== 1) begin
                errors++;
                $display("FAIL rand_done[%0d]: cycle %0d pulses %0d want %0d 1",
                         it, dc, nd, want);
            end
            checks++;
            if (wr_q.size() !== int'(l) || bo !== 0) begin
                errors++;
                $display("FAIL rand_writes[%0d]: got %0d overlap %0d want %0d 0",
                         it, wr_q.size(), bo, l);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_forward();
        test_overlap_back();
        test_wrap();
        test_len0();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
